// File: rtl/hex_display_bank_pkg.sv
// hexdisp_pkg: shared constants and helpers for the hex display bank.
// Segment patterns are active-low, bit0 = a ... bit6 = g.
package hexdisp_pkg;

   // All segments off (active-low)
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Active-low glyphs for hex digits, packed so SEG_TABLE[n] is the glyph for n
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'h0E,   // F
      7'h06,   // E
      7'h21,   // D
      7'h46,   // C
      7'h03,   // B
      7'h08,   // A
      7'h18,   // 9
      7'h00,   // 8
      7'h78,   // 7
      7'h02,   // 6
      7'h12,   // 5
      7'h19,   // 4
      7'h30,   // 3
      7'h24,   // 2
      7'h79,   // 1
      7'h40    // 0
   };

   // Look up the active-low glyph for one hex nibble
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      return SEG_TABLE[nib];
   endfunction

endpackage

// File: rtl/hex_display_bank_digit.sv
// hex_seg_digit: combinational single-digit hex decode with blank gating.
// When blank is high the digit is forced fully off.
module hex_seg_digit
   import hexdisp_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       blank,
   output logic [6:0] seg7
);

   // Decode the nibble unless the digit is being blanked
   always_comb begin
      seg7 = hex_to_seg(nibble);
      if (blank) begin
         seg7 = SEG_BLANK;
      end
   end

endmodule

// File: rtl/hex_display_bank.sv
// hex_display_bank: multi-digit active-low 7-segment hex display driver.
// Latches a hex word on a load strobe, then drives one registered segment
// field per digit with leading-zero blanking and optional per-digit blinking.
// Build option: define HEXDISP_BLINK_EN to build the blink counter; without it
// blink_phase is tied low and blink_mask has no effect.
module hex_display_bank
   import hexdisp_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int BLINK_DIV  = 25000000
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      load,
   input  logic [4*NUM_DIGITS-1:0]   value,
   input  logic                      blank_lz,
   input  logic [NUM_DIGITS-1:0]     blink_mask,
   output logic                      load_ack,
   output logic [4*NUM_DIGITS-1:0]   shown,
   output logic [7*NUM_DIGITS-1:0]   seg
);

   // Latch stage state
   logic [4*NUM_DIGITS-1:0] shown_q, shown_d;
   logic                    valid_q, valid_d;
   logic                    load_ack_q, load_ack_d;

   // Decode stage state
   logic [7*NUM_DIGITS-1:0] seg_q, seg_d;
   logic [7*NUM_DIGITS-1:0] seg_dec;

   // Per-digit blank terms
   logic [NUM_DIGITS-1:0]   lz_blank;
   logic [NUM_DIGITS-1:0]   digit_blank;
   logic                    blink_phase;

`ifdef HEXDISP_BLINK_EN
   localparam int CNT_W = $clog2(BLINK_DIV);

   logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
   logic             blink_phase_q, blink_phase_d;

   // Free-running blink divider: count 0..BLINK_DIV-1, flip the phase on wrap
   always_comb begin
      blink_cnt_d   = blink_cnt_q + CNT_W'(1);
      blink_phase_d = blink_phase_q;
      if (blink_cnt_q == CNT_W'(BLINK_DIV - 1)) begin
         blink_cnt_d   = '0;
         blink_phase_d = ~blink_phase_q;
      end
   end

   // Blink divider registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
      end else begin
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
      end
   end

   assign blink_phase = blink_phase_q;
`else
   // No divider in this build; the divide parameter is kept so both builds share a port/param list
   logic unused_blink_div;
   assign unused_blink_div = (BLINK_DIV < 2);
   assign blink_phase      = 1'b0;
`endif

   // Leading-zero detection: upper_zero[gi] is high when digits gi..NUM_DIGITS-1 are all zero.
   // Digit 0 is never blanked by this rule so an all-zero word still shows one "0".
   logic [NUM_DIGITS:1] upper_zero;
   assign upper_zero[NUM_DIGITS] = 1'b1;

   generate
      for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_upper_zero
         assign upper_zero[gi] = upper_zero[gi+1] & (shown_q[4*gi +: 4] == 4'h0);
      end

      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         if (gi == 0) begin : g_lz_first
            assign lz_blank[gi] = 1'b0;
         end else begin : g_lz_upper
            assign lz_blank[gi] = blank_lz & upper_zero[gi];
         end

         assign digit_blank[gi] = ~valid_q
                                | lz_blank[gi]
                                | (blink_phase & blink_mask[gi]);

         hex_seg_digit u_digit (
            .nibble (shown_q[4*gi +: 4]),
            .blank  (digit_blank[gi]),
            .seg7   (seg_dec[7*gi +: 7])
         );
      end
   endgenerate

   // Next-state for latch and decode stages; last load in a burst wins
   always_comb begin
      shown_d    = shown_q;
      valid_d    = valid_q;
      load_ack_d = load;
      seg_d      = seg_dec;
      if (load) begin
         shown_d = value;
         valid_d = 1'b1;
      end
   end

   // Latch and decode registers; reset blanks the display until the next load
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shown_q    <= '0;
         valid_q    <= 1'b0;
         load_ack_q <= 1'b0;
         seg_q      <= {NUM_DIGITS{SEG_BLANK}};
      end else begin
         shown_q    <= shown_d;
         valid_q    <= valid_d;
         load_ack_q <= load_ack_d;
         seg_q      <= seg_d;
      end
   end

   assign shown    = shown_q;
   assign load_ack = load_ack_q;
   assign seg      = seg_q;

endmodule
